tour_reader: RTL and testbench

//  Read-out end of the solver's path array: on start, snapshots path[] and streams the tour
//  (vertex index plus coordinates) over a valid/ready port.

---
 rtl/tour_reader.sv | 156 +++++++++++++++
 tb/tb_tour_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tour_reader.sv
// Tour read-out engine: snapshots the solver's path order on start, streams each
// vertex (position, id, coordinates) over valid/ready, and reports the saturating
// closed-tour Manhattan length plus a repeated-vertex flag.
module tour_reader #(
    parameter int unsigned N     = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] path [N-1:0],
    input  logic [31:0] xs   [N-1:0],
    input  logic [31:0] ys   [N-1:0],
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pos,
    output logic [31:0] out_idx,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        out_last,
    output logic        done,
    output logic [31:0] tour_length,
    output logic        perm_err
);

    localparam logic [IDX_W-1:0] KMax = IDX_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StStream, StClose, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q;
    logic [IDX_W-1:0]  path_snap [N-1:0];
    logic [2**IDX_W-1:0] seen_q;
    logic [31:0]       acc_q, px_q, py_q, fx_q, fy_q;

    logic              hs;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       cur_x, cur_y;
    logic [31:0]       step_acc, close_acc;
    logic              unused_path_hi;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Upper path bits are not part of the vertex id; fold them so they are visibly ignored.
    always_comb begin
        unused_path_hi = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            unused_path_hi = unused_path_hi ^ (^path[i][31:IDX_W]);
        end
    end

    // Current beat datapath and the two accumulator candidates.
    always_comb begin
        cur_idx   = path_snap[k_q];
        cur_x     = xs[cur_idx];
        cur_y     = ys[cur_idx];
        hs        = out_valid && out_ready;
        step_acc  = sat_add(sat_add(acc_q, abs_diff(cur_x, px_q)), abs_diff(cur_y, py_q));
        close_acc = sat_add(sat_add(acc_q, abs_diff(px_q, fx_q)), abs_diff(py_q, fy_q));
    end

    // Next-state logic and state-decoded outputs; stream outputs read zero outside STREAM.
    always_comb begin
        state_d   = state_q;
        out_valid = (state_q == StStream);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        out_pos   = '0;
        out_idx   = '0;
        out_x     = '0;
        out_y     = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_pos  = 32'(k_q);
            out_idx  = 32'(cur_idx);
            out_x    = cur_x;
            out_y    = cur_y;
            out_last = (k_q == KMax);
        end
        case (state_q)
            StIdle:   if (start) state_d = StStream;
            StStream: if (hs && (k_q == KMax)) state_d = StClose;
            StClose:  state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Control state, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            seen_q      <= '0;
            acc_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            perm_err    <= 1'b0;
            tour_length <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q      <= '0;
                        acc_q    <= '0;
                        seen_q   <= '0;
                        perm_err <= 1'b0;
                    end
                end
                StStream: begin
                    if (hs) begin
                        if (seen_q[cur_idx]) perm_err <= 1'b1;
                        seen_q[cur_idx] <= 1'b1;
                        if (k_q != '0) begin
                            acc_q <= step_acc;
                        end else begin
                            fx_q <= cur_x;
                            fy_q <= cur_y;
                        end
                        px_q <= cur_x;
                        py_q <= cur_y;
                        if (k_q != KMax) k_q <= k_q + 1'b1;
                    end
                end
                StClose: begin
                    // Result lands on entry to DONE so it is final while done is high.
                    acc_q       <= close_acc;
                    tour_length <= close_acc;
                end
                default: ;
            endcase
        end
    end

    // Path snapshot taken on the accepting edge; later solver writes are not seen.
    always_ff @(posedge clk) begin
        if ((state_q == StIdle) && start) begin
            for (int i = 0; i < int'(N); i++) begin
                path_snap[i] <= path[i][IDX_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_tour_reader.sv
// Directed bench for tour_reader: identity, swapped, backpressured, duplicated,
// saturating and mid-stream-reset read-outs with hand-computed lengths.
module tb_tour_reader;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [31:0] path [N-1:0];
    logic [31:0] xs   [N-1:0];
    logic [31:0] ys   [N-1:0];
    logic        busy, out_valid, out_last, done, perm_err;
    logic [31:0] out_pos, out_idx, out_x, out_y, tour_length;

    int vecs = 0;
    int errs = 0;
    logic [5:0] snap [N];

    logic [31:0] len;
    logic        perr;
    int          done_c, beats;

    tour_reader #(.N(N), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .path(path), .xs(xs), .ys(ys),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_pos(out_pos), .out_idx(out_idx), .out_x(out_x), .out_y(out_y),
        .out_last(out_last), .done(done), .tour_length(tour_length), .perm_err(perm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0 repeating from the first valid cycle.
    task automatic run_read(input int pat, input int rw_at, input int rst_at, input int pulse_at,
                            output logic [31:0] o_len, output logic o_perr,
                            output int o_done_c, output int o_beats);
        int c;
        bit fin;
        int idx;
        for (int i = 0; i < N; i++) snap[i] = path[i][5:0];
        o_len = '0; o_perr = 1'b0; o_done_c = -1; o_beats = 0;
        fin = 0;
        start = 1'b1; out_ready = 1'b1;
        tick;
        c = 1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (!fin && c < 400) begin
            start = (c == pulse_at);
            if (c == rw_at) for (int i = 0; i < N; i++) path[i] = 32'(N - 1 - i);
            if (out_valid) begin
                if (o_beats == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_valid", {31'd0, out_valid}, 32'd0);
                    chk("rst_pos", out_pos, 32'd0);
                    chk("rst_idx", out_idx, 32'd0);
                    chk("rst_x", out_x, 32'd0);
                    chk("rst_busy", {31'd0, busy}, 32'd0);
                    chk("rst_len", tour_length, 32'd0);
                    tick; tick;
                    rst = 1'b0;
                    for (int j = 0; j < 5; j++) begin
                        tick;
                        chk("rst_no_done", {31'd0, done}, 32'd0);
                    end
                    fin = 1;
                end else begin
                    idx = int'(snap[o_beats]);
                    chk("beat_pos", out_pos, 32'(o_beats));
                    chk("beat_idx", out_idx, 32'(idx));
                    chk("beat_x", out_x, xs[idx]);
                    chk("beat_y", out_y, ys[idx]);
                    chk("beat_last", {31'd0, out_last}, {31'd0, o_beats == N - 1});
                    out_ready = (pat == 0) || ((c - 1) % 3 == 0);
                    if (out_ready) o_beats++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (!fin && done) begin
                o_len = tour_length;
                o_perr = perm_err;
                o_done_c = c;
                tick;
                c++;
                chk("done_one_cycle", {31'd0, done}, 32'd0);
                chk("busy_after_done", {31'd0, busy}, 32'd0);
                fin = 1;
            end
            if (!fin) begin
                tick;
                c++;
            end
        end
        start = 1'b0;
        if (!fin) begin
            errs++;
            $error("FAIL timeout: observed no done within 400 cycles, required done");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            path[i] = 32'(i); xs[i] = 32'(i); ys[i] = 32'd0;
        end
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_len", tour_length, 32'd0);
        chk("reset_perm", {31'd0, perm_err}, 32'd0);
        chk("reset_pos", out_pos, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // 1: identity path on a line.
        run_read(0, -1, -1, -1, len, perr, done_c, beats);
        chk("c1_len", len, 32'd126);
        chk("c1_perm", {31'd0, perr}, 32'd0);
        chk("c1_done_cycle", 32'(done_c), 32'd66);
        chk("c1_beats", 32'(beats), 32'd64);

        // 2: positions 1 and 2 swapped.
        path[1] = 32'd2; path[2] = 32'd1;
        run_read(0, -1, -1, -1, len, perr, done_c, beats);
        chk("c2_len", len, 32'd128);
        chk("c2_perm", {31'd0, perr}, 32'd0);
        chk("c2_beats", 32'(beats), 32'd64);
        path[1] = 32'd1; path[2] = 32'd2;

        // 3: backpressure 1,0,0 with a stray start pulse mid-stream.
        run_read(1, -1, -1, 10, len, perr, done_c, beats);
        chk("c3_len", len, 32'd126);
        chk("c3_beats", 32'(beats), 32'd64);
        chk("c3_perm", {31'd0, perr}, 32'd0);
        chk("c3_hold_len", tour_length, 32'd126);

        // 4: duplicate vertex 7, path rewritten during the stream.
        path[5] = 32'd7; path[6] = 32'd7;
        run_read(0, 30, -1, -1, len, perr, done_c, beats);
        chk("c4_perm", {31'd0, perr}, 32'd1);
        chk("c4_len", len, 32'd126);
        chk("c4_beats", 32'(beats), 32'd64);
        for (int i = 0; i < N; i++) path[i] = 32'(i);

        // 5: huge x at vertex 0 saturates the length.
        for (int i = 0; i < N; i++) xs[i] = 32'd0;
        xs[0] = 32'hFFFF_FFFF;
        run_read(0, -1, -1, -1, len, perr, done_c, beats);
        chk("c5_len", len, 32'hFFFF_FFFF);
        chk("c5_perm", {31'd0, perr}, 32'd0);
        for (int i = 0; i < N; i++) xs[i] = 32'(i);

        // 6: reset at beat 20, then a fresh read-out from k=0.
        run_read(0, -1, 20, -1, len, perr, done_c, beats);
        chk("c6_beats_at_reset", 32'(beats), 32'd20);
        run_read(0, -1, -1, -1, len, perr, done_c, beats);
        chk("c6_len", len, 32'd126);
        chk("c6_beats", 32'(beats), 32'd64);
        chk("c6_done_cycle", 32'(done_c), 32'd66);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
